adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter_pkg.sv | 14 +
 rtl/ripple_carry_adder.sv | 23 ++
 rtl/adder_arbiter.sv | 109 ++++++++++
 tb/tb_adder_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the two-requester adder arbiter.
package adder_arbiter_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned NUM_REQ   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/ripple_carry_adder.sv
// Plain ripple-carry adder; the single arithmetic resource shared by the arbiter.
module ripple_carry_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter time-sharing one adder between two requesters,
// with an IDLE/EXEC/RESP handshake sequence and saturating statistics.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_overflow,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] ovf_count
);

    state_t           state;
    logic             rr_ptr;
    logic             gnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    logic             any_req;
    logic             grant;
    logic [WIDTH-1:0] add_sum;
    logic             add_ovf;
    logic             add_cout_unused;

    ripple_carry_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (op_a),
        .b    (op_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout_unused)
    );

    assign add_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (add_sum[WIDTH-1] != op_a[WIDTH-1]);

    // A lone requester wins outright; rr_ptr only breaks ties.
    always_comb begin
        any_req   = |req_valid;
        grant     = rr_ptr;
        req_ready = 2'b00;
        case (req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            default: grant = rr_ptr;
        endcase
        if (state == IDLE && any_req) begin
            req_ready = grant ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= 1'b0;
            gnt          <= 1'b0;
            op_a         <= '0;
            op_b         <= '0;
            rsp_valid    <= 2'b00;
            rsp_sum      <= '0;
            rsp_overflow <= 1'b0;
            op_count     <= '0;
            ovf_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        op_a  <= grant ? req1_a : req0_a;
                        op_b  <= grant ? req1_b : req0_b;
                        gnt   <= grant;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_sum      <= add_sum;
                    rsp_overflow <= add_ovf;
                    rsp_valid    <= gnt ? 2'b10 : 2'b01;
                    state        <= RESP;
                end
                RESP: begin
                    // Only the granted requester's ready bit can retire the result.
                    if (rsp_ready[gnt]) begin
                        rsp_valid <= 2'b00;
                        rr_ptr    <= ~gnt;
                        state     <= IDLE;
                        if (op_count != {CNT_W{1'b1}}) begin
                            op_count <= op_count + CNT_W'(1);
                        end
                        if (rsp_overflow && ovf_count != {CNT_W{1'b1}}) begin
                            ovf_count <= ovf_count + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter; a second instance with 2-bit counters covers saturation.
module tb_adder_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_sum;
    logic        rsp_overflow;
    logic [15:0] op_count, ovf_count;

    logic [1:0]  s_req_ready, s_rsp_valid;
    logic [31:0] s_rsp_sum;
    logic        s_rsp_overflow;
    logic [1:0]  s_op_count, s_ovf_count;

    int vectors;
    int errors;

    adder_arbiter #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_overflow(rsp_overflow),
        .op_count(op_count), .ovf_count(ovf_count)
    );

    adder_arbiter #(.WIDTH(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(s_req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(s_rsp_sum), .rsp_overflow(s_rsp_overflow),
        .op_count(s_op_count), .ovf_count(s_ovf_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, check the response cycle, then complete the handshake.
    task automatic one_op(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_sum, input logic exp_ovf, input string tag);
        req_valid = v;
        if (v == 2'b10) begin req1_a = a; req1_b = b; end
        else            begin req0_a = a; req0_b = b; end
        #1;
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(v));
        step();
        req_valid = 2'b00;
        chk({tag, "_exec_valid"}, 64'(rsp_valid), 64'd0);
        step();
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(v));
        chk({tag, "_sum"}, 64'(rsp_sum), 64'(exp_sum));
        chk({tag, "_ovf"}, 64'(rsp_overflow), 64'(exp_ovf));
        step();
        chk({tag, "_done_valid"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        vectors   = 0;
        errors    = 0;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_sum", 64'(rsp_sum), 64'd0);
        chk("reset_op_count", 64'(op_count), 64'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Single request from requester 0
        one_op(2'b01, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1'b0, "single");
        chk("single_op_count", 64'(op_count), 64'd1);
        chk("single_ovf_count", 64'(ovf_count), 64'd0);

        // Signed overflow and unsigned carry-out wrap
        one_op(2'b01, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, "ovf_pos");
        chk("ovf_pos_ovf_count", 64'(ovf_count), 64'd1);
        one_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, "wrap");
        chk("wrap_op_count", 64'(op_count), 64'd3);
        chk("wrap_ovf_count", 64'(ovf_count), 64'd1);

        // Requester 1 alone, once with rr_ptr=1 and once with rr_ptr=0
        one_op(2'b10, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, "neg_ovf");
        one_op(2'b10, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, "lone1");
        chk("lone1_op_count", 64'(op_count), 64'd5);
        chk("lone1_ovf_count", 64'(ovf_count), 64'd2);

        // Backpressure on requester 0 with requester 1 waiting; rsp_ready[1] must be ignored
        req0_a = 32'd1;   req0_b = 32'd2;
        req1_a = 32'h100; req1_b = 32'h200;
        rsp_ready = 2'b10;
        req_valid = 2'b11;
        #1;
        chk("bp_grant0", 64'(req_ready), 64'b01);
        step(); step();
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", 64'(rsp_valid), 64'b01);
            chk("bp_sum", 64'(rsp_sum), 64'd3);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            step();
        end
        rsp_ready = 2'b11;
        step();
        chk("bp_grant1", 64'(req_ready), 64'b10);
        step();
        req_valid = 2'b00;
        step();
        chk("bp_rsp1_valid", 64'(rsp_valid), 64'b10);
        chk("bp_rsp1_sum", 64'(rsp_sum), 64'h300);
        step();
        chk("bp_op_count", 64'(op_count), 64'd7);

        // Reset while holding a response
        rsp_ready = 2'b00;
        req0_a = 32'h7FFF_FFFF; req0_b = 32'h0000_0001;
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        step();
        chk("rst_pre_valid", 64'(rsp_valid), 64'b01);
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_sum", 64'(rsp_sum), 64'd0);
        chk("rst_ovf", 64'(rsp_overflow), 64'd0);
        chk("rst_op_count", 64'(op_count), 64'd0);
        chk("rst_ovf_count", 64'(ovf_count), 64'd0);
        step();
        rst_n = 1'b1;
        rsp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_post_valid", 64'(rsp_valid), 64'd0);
        end
        chk("rst_post_op_count", 64'(op_count), 64'd0);

        // Continuous contention: grants alternate starting with requester 0
        req0_a = 32'd10; req0_b = 32'd1;
        req1_a = 32'd20; req1_b = 32'd2;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_grant", 64'(req_ready), (i % 2 == 0) ? 64'b01 : 64'b10);
            step(); step();
            chk("cont_rsp_valid", 64'(rsp_valid), (i % 2 == 0) ? 64'b01 : 64'b10);
            chk("cont_sum", 64'(rsp_sum), (i % 2 == 0) ? 64'd11 : 64'd22);
            step();
        end
        req_valid = 2'b00;
        chk("cont_op_count", 64'(op_count), 64'd4);
        chk("cont_ovf_count", 64'(ovf_count), 64'd0);
        chk("sat_op_pre", 64'(s_op_count), 64'd3);

        // Saturation on the 2-bit counter instance
        for (int i = 0; i < 5; i++) begin
            one_op(2'b01, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, "sat");
            chk("sat_ovf_count_s", 64'(s_ovf_count), (i < 3) ? 64'(i + 1) : 64'd3);
        end
        chk("sat_op_count_s", 64'(s_op_count), 64'd3);
        chk("sat_op_count_wide", 64'(op_count), 64'd9);
        chk("sat_ovf_count_wide", 64'(ovf_count), 64'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
